demux_pipe: RTL and testbench
=============================

Name: demux_pipe

Overview:
- Pipelined 1-to-N demultiplexer with valid/ready flow control. It is the distribution counterpart of the combinational mux.
- Steers one input word stream to one of N output channels, chosen per beat by a select field.
- Each output channel has a 2-entry skid buffer, so input ready never depends combinationally on output ready.
- Sits at NoC router egress and fan-out points, driving independent downstream consumers.

Parameters:
- N, 4, number of output channels; legal range N >= 2.
- W, 32, data word width in bits.
- L, $clog2(N), select width; derived localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- s  input  L  output channel select; sampled only when i_valid is 1.
- i_valid  input  1  input beat valid.
- i_ready  output  1  input beat accepted when i_valid & i_ready.
- i  input  W  input data word.
- o_valid  output  N  per-channel valid.
- o_ready  input  N  per-channel downstream ready.
- o  output  N*W  packed [N-1:0][W-1:0] per-channel data.
- drop_cnt  output  16  saturating count of beats dropped for an out-of-range select.

Behaviour:
- Reset: clk is the single clock. rst_n is asynchronous assert, synchronous deassert externally.
  - While rst_n=0: all slots empty, o_valid=0, o=0, drop_cnt=0, i_ready=0.
- Per-channel slot (2-entry FIFO): registers d0 (head) and d1, plus cnt in {0,1,2}.
  - o[k]=d0, o_valid[k]=(cnt!=0).
  - States: EMPTY (cnt=0), ONE (cnt=1), FULL (cnt=2).
- i_ready:
  - s<N: i_ready = (cnt[s]!=2). This is a registered-state function only; there is no combinational path from o_ready.
  - s>=N: i_ready = 1 (the beat is consumed and dropped).
  - i_ready is valid only while i_valid=1; it is don't-care otherwise.
- Push/pop for each channel k, per cycle:
  - push = i_valid & i_ready & (s==k).
  - pop = o_valid[k] & o_ready[k].
  - EMPTY, push: d0<=i, go to ONE.
  - ONE, push & !pop: d1<=i, go to FULL.
  - ONE, push & pop: d0<=i, stay ONE.
  - ONE, pop only: go to EMPTY.
  - FULL, pop: d0<=d1, go to ONE. Push is impossible in FULL because i_ready=0.
- Latency: a beat accepted at edge t appears on o_valid[s]/o[s] after edge t (one cycle). Back-to-back beats to one channel sustain 1 beat/cycle while o_ready is held at 1.
- Ordering: FIFO order is preserved per channel. There is no ordering guarantee across channels.
- Out-of-range select (only possible when N is not a power of 2): the beat is accepted and discarded, and drop_cnt increments. drop_cnt holds at 16'hFFFF and never wraps.
- Blocking: a FULL destination stalls the input, including beats queued behind it for other channels (head-of-line blocking is intentional).
- Unselected channels drain independently, regardless of input activity.
- Data in empty entries retains its old value; only o_valid qualifies o.
- Reset mid-operation: all buffered beats are lost immediately, o_valid drops asynchronously, and drop_cnt clears.
- X-safety: s, i and o_ready are ignored when i_valid/o_valid are 0. There are no asserts on them in that case.

Decomposition:
- Shared noc package holds:
  - the drop counter width constant, DROP_CNT_W=16;
  - a generic function returning the select width ($clog2 wrapper), shared with mux.
- Sub-module skid_slot #(W): a 2-entry FIFO with push/pop/cnt and ports clk, rst_n, push, d, full, valid, ready, q.
  - demux_pipe instantiates N copies in a generate loop, plus the select decode and drop counter.

Test Plan:
- Basic steering (N=4, W=32, o_ready=4'hF):
  - Send 32'hABCDABCD with s=0, 32'h12341234 with s=1, 32'h56785678 with s=2, 32'hEFEFEFEF with s=3 on consecutive cycles.
  - Each appears on its channel exactly one cycle after acceptance; all other o_valid stay 0.
- Backpressure/skid:
  - With o_ready[1]=0, send three beats to s=1: 32'h1, 32'h2, 32'h3.
  - First two are accepted; i_ready=0 on the third.
  - Raise o_ready[1]: the channel outputs 1, 2, 3 in order, with no loss or duplication.
- Simultaneous push/pop:
  - Channel 2 in ONE holding 32'hA, o_ready[2]=1, push 32'hB.
  - Next cycle o[2]=32'hB, cnt stays 1, i_ready stays 1.
- Out-of-range (N=6, L=3):
  - Send s=3'b110 and 3'b111 with 32'hFFFFFFFF.
  - i_ready=1, no o_valid asserted, drop_cnt=2.
  - Preload the counter to 16'hFFFE and send 3 more out-of-range beats: drop_cnt=16'hFFFF.
- Independent drain:
  - Channel 0 FULL with o_ready[0]=0, channel 3 holds 32'h00000000 with o_ready[3]=1.
  - Channel 3 drains while the input is stalled on s=0.
- Reset mid-operation:
  - Fill channels 0 and 3, deassert rst_n between clock edges.
  - o_valid=0 and drop_cnt=0 immediately, without a clock edge.
  - After release, a new beat to s=3 appears alone on channel 3 with no stale data.

Source files
------------

// File: rtl/demux_pipe_pkg.sv
// -----------------------------------------------------------------------------
// demux_pipe_pkg
//   Shared NoC definitions used by the demux/mux family:
//     DROP_CNT_W   - width of the saturating out-of-range drop counter
//     slot_state_t - occupancy states of a 2-entry skid slot
//     sel_width()  - select-field width for an N-way steer ($clog2 wrapper)
// -----------------------------------------------------------------------------
package demux_pipe_pkg;

    localparam int unsigned DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_ONE   = 2'd1,
        SLOT_FULL  = 2'd2
    } slot_state_t;

    // A 1-way select would give a zero-width field; clamp to 1 bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demux_pipe_skid_slot.sv
// -----------------------------------------------------------------------------
// skid_slot
//   Two-entry FIFO used as the per-channel output buffer of demux_pipe.
//   The head entry drives q directly, so data leaves straight from a flop.
//   Ports:
//     clk, rst_n - clock, asynchronous active-low reset
//     push, d    - write strobe and data (caller guarantees !full on push)
//     full       - both entries occupied (registered)
//     valid      - at least one entry occupied (registered)
//     ready      - downstream accepts the head entry this cycle
//     q          - head entry data; retains old contents when empty
// -----------------------------------------------------------------------------
module skid_slot
    import demux_pipe_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] d,
    output logic         full,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] q
);

    slot_state_t  state;
    logic [W-1:0] d1;
    logic         pop;

    assign pop = valid & ready;

    // valid/full are kept as flops alongside the state so neither output
    // depends on a decode of the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
            valid <= 1'b0;
            full  <= 1'b0;
            q     <= '0;
            d1    <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (push) begin
                        q     <= d;
                        state <= SLOT_ONE;
                        valid <= 1'b1;
                    end
                end
                SLOT_ONE: begin
                    if (push && !pop) begin
                        d1    <= d;
                        state <= SLOT_FULL;
                        full  <= 1'b1;
                    end else if (push && pop) begin
                        // Head leaves and the new beat takes its place.
                        q <= d;
                    end else if (pop) begin
                        state <= SLOT_EMPTY;
                        valid <= 1'b0;
                    end
                end
                SLOT_FULL: begin
                    if (pop) begin
                        q     <= d1;
                        state <= SLOT_ONE;
                        full  <= 1'b0;
                    end
                end
                default: begin
                    state <= SLOT_EMPTY;
                    valid <= 1'b0;
                    full  <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full));
        end
    end
`endif

endmodule

// File: rtl/demux_pipe.sv
// -----------------------------------------------------------------------------
// demux_pipe
//   Pipelined 1-to-N demultiplexer with valid/ready flow control. Each beat is
//   steered to channel s and buffered in a 2-entry skid slot, so i_ready is a
//   function of registered occupancy only. Beats whose select is >= N are
//   accepted and discarded, counted by a saturating drop counter.
//   Ports:
//     clk, rst_n - clock, asynchronous active-low reset
//     s          - destination channel select (used only with i_valid)
//     i_valid    - input beat valid
//     i_ready    - input beat accepted when i_valid & i_ready
//     i          - input data word
//     o_valid    - per-channel valid
//     o_ready    - per-channel downstream ready
//     o          - per-channel data, packed [N-1:0][W-1:0]
//     drop_cnt   - saturating count of out-of-range beats
// -----------------------------------------------------------------------------
module demux_pipe
    import demux_pipe_pkg::*;
#(
    parameter  int unsigned N = 4,
    parameter  int unsigned W = 32,
    localparam int unsigned L = sel_width(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [L-1:0]          s,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [W-1:0]          i,
    output logic [N-1:0]          o_valid,
    input  logic [N-1:0]          o_ready,
    output logic [N-1:0][W-1:0]   o,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned LP1   = L + 1;
    localparam logic [L:0]  N_EXT = LP1'(N);

    logic [N-1:0] full;
    logic [N-1:0] push;
    logic         sel_full;
    logic         out_of_range;
    logic         drop;

    // Only reachable when N is not a power of two.
    assign out_of_range = ({1'b0, s} >= N_EXT);

    always_comb begin
        sel_full = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (s == L'(k)) begin
                sel_full = full[k];
            end
        end
    end

    // Out-of-range beats are always consumed; held low throughout reset.
    assign i_ready = rst_n & (out_of_range | ~sel_full);

    always_comb begin
        push = '0;
        for (int unsigned k = 0; k < N; k++) begin
            push[k] = i_valid & i_ready & (s == L'(k));
        end
    end

    assign drop = i_valid & i_ready & out_of_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        skid_slot #(
            .W (W)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .d     (i),
            .full  (full[k]),
            .valid (o_valid[k]),
            .ready (o_ready[k]),
            .q     (o[k])
        );
    end

endmodule

// File: tb/tb_demux_pipe.sv
module tb_demux_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    // DUT A: N=4 (power of two)
    logic [1:0]       sa;
    logic             va;
    logic [31:0]      ia;
    logic [3:0]       ora;
    logic             ira;
    logic [3:0]       ova;
    logic [3:0][31:0] oa;
    logic [15:0]      dropa;

    // DUT B: N=6 (out-of-range selects possible)
    logic [2:0]       sb;
    logic             vb;
    logic [31:0]      ib;
    logic [5:0]       orb;
    logic             irb;
    logic [5:0]       ovb;
    logic [5:0][31:0] ob;
    logic [15:0]      dropb;

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-DUT, per-channel FIFO of words plus drop count.
    logic [31:0] mq [2][6][$];
    int unsigned mdrop [2];

    demux_pipe #(.N(4), .W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .s(sa), .i_valid(va), .i_ready(ira), .i(ia),
        .o_valid(ova), .o_ready(ora), .o(oa), .drop_cnt(dropa)
    );

    demux_pipe #(.N(6), .W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .s(sb), .i_valid(vb), .i_ready(irb), .i(ib),
        .o_valid(ovb), .o_ready(orb), .o(ob), .drop_cnt(dropb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mstep(input int d, input int n, input int sel, input logic v,
                         input logic [31:0] din, input logic [5:0] ordy);
        bit acc;
        if (sel >= n) acc = v;
        else          acc = v && (mq[d][sel].size() < 2);
        for (int k = 0; k < n; k++) begin
            if (mq[d][k].size() != 0 && ordy[k]) void'(mq[d][k].pop_front());
        end
        if (acc) begin
            if (sel >= n) begin
                if (mdrop[d] < 65535) mdrop[d]++;
            end else begin
                mq[d][sel].push_back(din);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mdrop[d] = 0;
                for (int k = 0; k < 6; k++) mq[d][k].delete();
            end
        end else begin
            mstep(0, 4, int'(sa), va, ia, {2'b00, ora});
            mstep(1, 6, int'(sb), vb, ib, orb);
        end
    end

    task automatic mcheck(input int d, input int n, input logic [5:0] ov,
                          input logic [5:0][31:0] od, input logic ir,
                          input logic [15:0] dc, input int sel, input logic v);
        logic ev;
        logic eir;
        if (!rst_n) begin
            chk($sformatf("rst_valid%0d", d), 32'(ov), 32'd0);
            chk($sformatf("rst_ready%0d", d), 32'(ir), 32'd0);
            chk($sformatf("rst_drop%0d", d), 32'(dc), 32'd0);
            for (int k = 0; k < n; k++) chk($sformatf("rst_data%0d_%0d", d, k), od[k], 32'd0);
        end else begin
            for (int k = 0; k < n; k++) begin
                ev = (mq[d][k].size() != 0);
                chk($sformatf("valid%0d_%0d", d, k), 32'(ov[k]), 32'(ev));
                if (ev) chk($sformatf("data%0d_%0d", d, k), od[k], mq[d][k][0]);
            end
            if (v) begin
                if (sel >= n) eir = 1'b1;
                else          eir = (mq[d][sel].size() < 2);
                chk($sformatf("i_ready%0d", d), 32'(ir), 32'(eir));
            end
            chk($sformatf("drop%0d", d), 32'(dc), mdrop[d]);
        end
    endtask

    always @(negedge clk) begin
        mcheck(0, 4, {2'b00, ova}, {64'd0, oa}, ira, dropa, int'(sa), va);
        mcheck(1, 6, ovb, ob, irb, dropb, int'(sb), vb);
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] steer [4];

    initial begin
        steer[0] = 32'hABCDABCD; steer[1] = 32'h12341234;
        steer[2] = 32'h56785678; steer[3] = 32'hEFEFEFEF;
        sa = '0; va = 1'b0; ia = '0; ora = '1;
        sb = '0; vb = 1'b0; ib = '0; orb = '1;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ova", 32'(ova), 32'd0);
        chk("reset_ovb", 32'(ovb), 32'd0);
        chk("reset_ira", 32'(ira), 32'd0);
        chk("reset_dropb", 32'(dropb), 32'd0);
        rst_n = 1'b1;
        cyc;

        // Basic steering, one cycle latency, others stay idle
        for (int k = 0; k < 4; k++) begin
            sa = 2'(k); ia = steer[k]; va = 1'b1;
            cyc;
            chk("steer_valid", 32'(ova), 32'd1 << k);
            chk("steer_data", oa[k], steer[k]);
        end
        va = 1'b0;
        cyc;
        chk("steer_idle", 32'(ova), 32'd0);

        // Backpressure / skid on channel 1
        ora = 4'b1101; sa = 2'd1; va = 1'b1; ia = 32'h1;
        cyc;
        ia = 32'h2;
        cyc;
        ia = 32'h3;
        chk("bp_ready_full", 32'(ira), 32'd0);
        chk("bp_head1", oa[1], 32'h1);
        ora = 4'b1111;
        cyc;
        chk("bp_head2", oa[1], 32'h2);
        chk("bp_ready_again", 32'(ira), 32'd1);
        cyc;
        chk("bp_head3", oa[1], 32'h3);
        va = 1'b0;
        cyc;
        chk("bp_drained", 32'(ova), 32'd0);

        // Simultaneous push/pop on channel 2
        ora = 4'b1011; sa = 2'd2; ia = 32'hA; va = 1'b1;
        cyc;
        ora = 4'b1111; ia = 32'hB;
        chk("pp_ready_before", 32'(ira), 32'd1);
        cyc;
        chk("pp_data", oa[2], 32'hB);
        chk("pp_valid", 32'(ova), 32'b0100);
        chk("pp_ready_after", 32'(ira), 32'd1);
        va = 1'b0;
        cyc;

        // Independent drain: channel 0 full and stalled, channel 3 drains
        ora = 4'b0000; sa = 2'd3; ia = 32'h0; va = 1'b1;
        cyc;
        sa = 2'd0; ia = 32'h11;
        cyc;
        ia = 32'h22;
        cyc;
        ia = 32'h33; ora = 4'b1000;
        #1;
        chk("drain_stall", 32'(ira), 32'd0);
        chk("drain_valid_before", 32'(ova), 32'b1001);
        cyc;
        chk("drain_valid_after", 32'(ova), 32'b0001);
        chk("drain_still_stall", 32'(ira), 32'd0);
        chk("drain_head0", oa[0], 32'h11);

        // Out-of-range on N=6
        vb = 1'b1; sb = 3'b110; ib = 32'hFFFFFFFF;
        #1;
        chk("oor_ready", 32'(irb), 32'd1);
        cyc;
        sb = 3'b111;
        cyc;
        vb = 1'b0;
        chk("oor_novalid", 32'(ovb), 32'd0);
        chk("oor_drop2", 32'(dropb), 32'd2);

        // Fill channel 3 of A and channels 0/3 of B, then reset between edges
        sa = 2'd3; ia = 32'h77; va = 1'b1;
        orb = 6'd0; sb = 3'd0; ib = 32'h99; vb = 1'b1;
        cyc;
        ora = 4'b0000; va = 1'b0;
        sb = 3'd3;
        cyc;
        vb = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ova", 32'(ova), 32'd0);
        chk("mid_rst_ovb", 32'(ovb), 32'd0);
        chk("mid_rst_dropb", 32'(dropb), 32'd0);
        chk("mid_rst_oa0", oa[0], 32'd0);
        cyc;
        cyc;
        rst_n = 1'b1;
        ora = 4'b1111; orb = '1;
        cyc;
        sa = 2'd3; ia = 32'h5A5A5A5A; va = 1'b1;
        cyc;
        chk("post_rst_valid", 32'(ova), 32'b1000);
        chk("post_rst_data", oa[3], 32'h5A5A5A5A);
        va = 1'b0;
        cyc;

        // Randomized traffic on both DUTs
        repeat (1500) begin
            va = ($urandom_range(0, 3) != 0); sa = 2'($urandom); ia = $urandom; ora = 4'($urandom);
            vb = ($urandom_range(0, 3) != 0); sb = 3'($urandom); ib = $urandom; orb = 6'($urandom);
            cyc;
        end
        va = 1'b0; vb = 1'b0; ora = '1; orb = '1;
        cyc;

        // Drive the drop counter up to the saturation point
        vb = 1'b1;
        for (int n = 0; n < 70000 && mdrop[1] < 65534; n++) begin
            sb = 3'(6 + $urandom_range(0, 1)); ib = $urandom;
            cyc;
        end
        vb = 1'b0;
        chk("sat_preload", 32'(dropb), 32'hFFFE);
        vb = 1'b1; sb = 3'b110;
        repeat (3) cyc;
        vb = 1'b0;
        chk("sat_hold", 32'(dropb), 32'hFFFF);
        cyc;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
